// File: rtl/gps_pkg.sv
// Shared definitions for the GPS UART-to-GPZDA feed path: FSM encoding,
// sentence start byte and the saturating counter helper.
package gps_pkg;

    localparam int unsigned DefaultB = 8;
    localparam logic [7:0] DollarByte = 8'h24;

    typedef enum logic [1:0] {
        StHunt,
        StRestart,
        StFeed
    } state_e;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/gps_feed_controller_byte_fifo.sv
// Power-of-two byte FIFO with show-ahead head data and synchronous flush.
module byte_fifo
    import gps_pkg::*;
#(
    parameter int unsigned B     = DefaultB,
    parameter int unsigned Depth = 16
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  logic [B-1:0] wdata,
    output logic [B-1:0] rdata,
    output logic         full,
    output logic         empty
);

    localparam int unsigned AW = $clog2(Depth);

    logic [B-1:0] mem [Depth];
    logic [AW:0]  wptr_q, rptr_q;
    logic         do_push, do_pop;

    assign empty   = (wptr_q == rptr_q);
    assign full    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rptr_q[AW-1:0]];

    always_ff @(posedge clock) begin
        if (do_push && !flush) begin
            mem[wptr_q[AW-1:0]] <= wdata;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else if (flush) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + (AW+1)'(1);
            if (do_pop)  rptr_q <= rptr_q + (AW+1)'(1);
        end
    end

endmodule

// File: rtl/gps_feed_controller.sv
// Buffers UART bytes, frames GPZDA sentences on '$' and feeds them to the
// receiver with a minimum load spacing, tracking good/bad sentence outcomes.
module gps_feed_controller
    import gps_pkg::*;
#(
    parameter int unsigned B             = DefaultB,
    parameter int unsigned Depth         = 16,
    parameter int unsigned Gap           = 1,
    parameter int unsigned TimeoutCycles = 1000000
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic         rx_valid,
    input  logic [B-1:0] rx_data,
    input  logic         rx_error,
    output logic         rcv_restart,
    output logic         rcv_load,
    output logic [B-1:0] rcv_data,
    input  logic         rcv_resolve,
    input  logic         rcv_error,
    output logic         frame_good,
    output logic         frame_bad,
    output logic         overflow,
    output logic [15:0]  good_count,
    output logic [15:0]  bad_count
);

    localparam int unsigned GapW  = $clog2(Gap + 1);
    localparam int unsigned TimeW = $clog2(TimeoutCycles + 1);
    localparam logic [B-1:0] Dollar = B'(DollarByte);

    state_e           state_q;
    logic [GapW-1:0]  gap_q;
    logic [TimeW-1:0] tout_q;
    logic             first_q;

    logic         push, pop, flush, full, empty;
    logic [B-1:0] head;
    logic         push_try, rx_err_strobe, head_dollar, in_feed;
    logic         tout_hit, resync, ovf_event;

    assign push_try      = rx_valid && !rx_error;
    assign rx_err_strobe = rx_valid && rx_error;
    assign head_dollar   = !empty && (head == Dollar);
    assign in_feed       = (state_q == StFeed);
    assign tout_hit      = in_feed && empty && (tout_q == TimeW'(TimeoutCycles - 1));
    assign resync        = in_feed && head_dollar && !first_q;
    // pop never depends on the overflow abort, which keeps this loop-free
    assign ovf_event     = push_try && full && !pop;
    assign flush         = in_feed && !rcv_resolve && (rx_err_strobe || ovf_event);
    assign push          = push_try && (!full || pop);

    always_comb begin
        pop = 1'b0;
        unique case (state_q)
            StHunt:  pop = !empty && !head_dollar;
            StFeed:  pop = !rcv_resolve && !rx_err_strobe && !tout_hit && !resync &&
                           !empty && (gap_q == '0);
            default: pop = 1'b0;
        endcase
    end

    byte_fifo #(
        .B     (B),
        .Depth (Depth)
    ) u_fifo (
        .clock   (clock),
        .reset_n (reset_n),
        .push    (push),
        .pop     (pop),
        .flush   (flush),
        .wdata   (rx_data),
        .rdata   (head),
        .full    (full),
        .empty   (empty)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= StHunt;
            gap_q       <= '0;
            tout_q      <= '0;
            first_q     <= 1'b0;
            rcv_restart <= 1'b0;
            rcv_load    <= 1'b0;
            rcv_data    <= '0;
            frame_good  <= 1'b0;
            frame_bad   <= 1'b0;
            overflow    <= 1'b0;
            good_count  <= '0;
            bad_count   <= '0;
        end else begin
            rcv_restart <= 1'b0;
            rcv_load    <= 1'b0;
            frame_good  <= 1'b0;
            frame_bad   <= 1'b0;
            if (gap_q != '0) gap_q <= gap_q - GapW'(1);

            if (ovf_event) begin
                overflow <= 1'b1;
            end else if (state_q == StHunt && head_dollar) begin
                overflow <= 1'b0;
            end

            unique case (state_q)
                StHunt: begin
                    tout_q <= '0;
                    if (head_dollar) state_q <= StRestart;
                end
                StRestart: begin
                    rcv_restart <= 1'b1;
                    first_q     <= 1'b1;
                    tout_q      <= '0;
                    state_q     <= StFeed;
                end
                StFeed: begin
                    if (rcv_resolve) begin
                        frame_good <= !rcv_error;
                        frame_bad  <= rcv_error;
                        if (rcv_error) bad_count  <= sat_inc(bad_count);
                        else           good_count <= sat_inc(good_count);
                        tout_q  <= '0;
                        state_q <= StHunt;
                    end else if (flush || tout_hit) begin
                        frame_bad <= 1'b1;
                        bad_count <= sat_inc(bad_count);
                        tout_q    <= '0;
                        state_q   <= StHunt;
                    end else if (resync) begin
                        // leave the new '$' in place so it starts the next sentence
                        frame_bad <= 1'b1;
                        bad_count <= sat_inc(bad_count);
                        tout_q    <= '0;
                        state_q   <= StRestart;
                    end else if (pop) begin
                        rcv_load <= 1'b1;
                        rcv_data <= head;
                        gap_q    <= GapW'(Gap);
                        first_q  <= 1'b0;
                        tout_q   <= '0;
                    end else if (empty) begin
                        tout_q <= tout_q + TimeW'(1);
                    end
                end
                default: state_q <= StHunt;
            endcase
        end
    end

endmodule

// File: tb/tb_gps_feed_controller.sv
// Scoreboard bench for gps_feed_controller with a checksum-verifying receiver model.
`timescale 1ns/1ps
module tb_gps_feed_controller;
    import gps_pkg::*;

    localparam int unsigned B = 8;
    localparam int unsigned Depth = 16;
    localparam int unsigned Gap = 3;
    localparam int unsigned TimeoutCycles = 100;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    logic rx_valid = 1'b0;
    logic rx_error = 1'b0;
    logic [B-1:0] rx_data = '0;
    logic rcv_resolve = 1'b0;
    logic rcv_error = 1'b0;
    logic rcv_restart, rcv_load, frame_good, frame_bad, overflow;
    logic [B-1:0] rcv_data;
    logic [15:0] good_count, bad_count;

    gps_feed_controller #(
        .B             (B),
        .Depth         (Depth),
        .Gap           (Gap),
        .TimeoutCycles (TimeoutCycles)
    ) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .rx_valid    (rx_valid),
        .rx_data     (rx_data),
        .rx_error    (rx_error),
        .rcv_restart (rcv_restart),
        .rcv_load    (rcv_load),
        .rcv_data    (rcv_data),
        .rcv_resolve (rcv_resolve),
        .rcv_error   (rcv_error),
        .frame_good  (frame_good),
        .frame_bad   (frame_bad),
        .overflow    (overflow),
        .good_count  (good_count),
        .bad_count   (bad_count)
    );

    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int n_restart = 0, n_good = 0, n_bad = 0, n_load = 0;
    int t_restart = 0, t_bad = 0, t_load = 0;
    bit want_dollar = 1'b0;
    logic [7:0] sbq[$];
    logic [7:0] sent[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] hexc(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + 8'(n)) : (8'h41 + 8'(n) - 8'd10);
    endfunction

    task automatic make_sentence(input string body);
        logic [7:0] xs;
        xs = 8'h00;
        sent.delete();
        sent.push_back(8'h24);
        for (int i = 0; i < body.len(); i++) begin
            sent.push_back(body[i]);
            xs ^= body[i];
        end
        sent.push_back(8'h2A);
        sent.push_back(hexc(xs[7:4]));
        sent.push_back(hexc(xs[3:0]));
    endtask

    // Called at a negedge; returns at a negedge `spacing` cycles later.
    task automatic send_byte(input logic [7:0] b, input bit expect_load, input int spacing);
        rx_valid = 1'b1;
        rx_data  = b;
        if (expect_load) sbq.push_back(b);
        @(negedge clock);
        rx_valid = 1'b0;
        repeat (spacing - 1) @(negedge clock);
    endtask

    task automatic send_sent(input int n, input int spacing);
        for (int i = 0; i < n; i++) send_byte(sent[i], 1'b1, spacing);
    endtask

    task automatic send_junk(input string s);
        for (int i = 0; i < s.len(); i++) send_byte(s[i], 1'b0, 10);
    endtask

    task automatic check_outputs_zero(input string tag);
        check_eq({tag, "_restart"}, rcv_restart, 0);
        check_eq({tag, "_load"}, rcv_load, 0);
        check_eq({tag, "_data"}, rcv_data, 0);
        check_eq({tag, "_good"}, frame_good, 0);
        check_eq({tag, "_bad"}, frame_bad, 0);
        check_eq({tag, "_overflow"}, overflow, 0);
        check_eq({tag, "_good_count"}, good_count, 0);
        check_eq({tag, "_bad_count"}, bad_count, 0);
    endtask

    // Output monitor, scoreboard pop and GPZDA receiver model.
    initial begin : monitor
        logic [7:0] xs, h1;
        int ph;
        xs = 8'h00;
        h1 = 8'h00;
        ph = 0;
        forever begin
            @(negedge clock);
            cyc++;
            rcv_resolve = 1'b0;
            rcv_error   = 1'b0;
            if (!reset_n) begin
                ph = 0;
                want_dollar = 1'b0;
            end else begin
                if (rcv_restart) begin
                    n_restart++;
                    t_restart = cyc;
                    want_dollar = 1'b1;
                    ph = 0;
                end
                if (frame_good) n_good++;
                if (frame_bad) begin
                    n_bad++;
                    t_bad = cyc;
                end
                if (rcv_load) begin
                    n_load++;
                    t_load = cyc;
                    if (want_dollar) begin
                        check_eq("first_load_dollar", rcv_data, 8'h24);
                        want_dollar = 1'b0;
                    end
                    check_eq("sb_has_entry", sbq.size() > 0, 1);
                    if (sbq.size() > 0) check_eq("load_data", rcv_data, sbq.pop_front());
                    if (rcv_data == 8'h24) begin
                        ph = 1;
                        xs = 8'h00;
                    end else begin
                        case (ph)
                            1: if (rcv_data == 8'h2A) ph = 2; else xs ^= rcv_data;
                            2: begin h1 = rcv_data; ph = 3; end
                            3: begin
                                rcv_resolve = 1'b1;
                                rcv_error = ({h1, rcv_data} != {hexc(xs[7:4]), hexc(xs[3:0])});
                                ph = 0;
                            end
                            default: ph = 0;
                        endcase
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int r0, g0, b0, l0;
        repeat (3) @(negedge clock);
        check_outputs_zero("reset");
        check_eq("reset_state", 32'(dut.state_q), 32'(StHunt));
        check_eq("reset_fifo_empty", dut.u_fifo.empty, 1);
        reset_n = 1'b1;
        repeat (5) @(negedge clock);

        // Clean sentence, one byte per 10 cycles
        r0 = n_restart; g0 = n_good;
        make_sentence("GPZDA,201530.00,04,07,2002,00,00");
        send_sent(sent.size(), 10);
        repeat (30) @(negedge clock);
        check_eq("s1_restarts", n_restart - r0, 1);
        check_eq("s1_good_pulses", n_good - g0, 1);
        check_eq("s1_good_count", good_count, 1);
        check_eq("s1_bad_count", bad_count, 0);
        check_eq("s1_sb_drained", sbq.size(), 0);

        // Leading junk is discarded before the sentence
        r0 = n_restart; l0 = n_load;
        send_junk("xyz\r\n");
        repeat (10) @(negedge clock);
        check_eq("junk_no_loads", n_load - l0, 0);
        check_eq("junk_no_restart", n_restart - r0, 0);
        make_sentence("GPZDA,201531.00,04,07,2002,00,00");
        send_sent(sent.size(), 10);
        repeat (30) @(negedge clock);
        check_eq("s2_restarts", n_restart - r0, 1);
        check_eq("s2_good_count", good_count, 2);
        check_eq("s2_sb_drained", sbq.size(), 0);

        // Back-to-back burst outruns the Gap-limited drain and overflows
        b0 = n_bad;
        make_sentence("GPZDA,201532.00,04,07,2002,00,00");
        send_sent(24, 1);
        repeat (40) @(negedge clock);
        check_eq("ovf_sticky", overflow, 1);
        check_eq("ovf_bad_pulses", n_bad - b0, 1);
        check_eq("ovf_bad_count", bad_count, 1);
        check_eq("ovf_good_count", good_count, 2);
        check_eq("ovf_fifo_empty", dut.u_fifo.empty, 1);
        check_eq("ovf_state", 32'(dut.state_q), 32'(StHunt));
        sbq.delete();

        // '$' injected at byte 12 forces a resync onto the new sentence
        b0 = n_bad; g0 = n_good; r0 = n_restart;
        make_sentence("GPZDA,201533.00,04,07,2002,00,00");
        send_sent(12, 10);
        make_sentence("GPZDA,201534.00,04,07,2002,00,00");
        send_sent(sent.size(), 10);
        repeat (30) @(negedge clock);
        check_eq("resync_bad_pulses", n_bad - b0, 1);
        check_eq("resync_restarts", n_restart - r0, 2);
        check_eq("resync_restart_after_bad", t_restart > t_bad, 1);
        check_eq("resync_good_pulses", n_good - g0, 1);
        check_eq("resync_counts", {good_count, bad_count}, {16'd3, 16'd2});
        check_eq("resync_ovf_cleared", overflow, 0);
        check_eq("resync_sb_drained", sbq.size(), 0);

        // Input stops after 8 bytes: timeout abort
        b0 = n_bad;
        make_sentence("GPZDA,201535.00,04,07,2002,00,00");
        send_sent(8, 10);
        for (int i = 0; i < 300 && n_bad == b0; i++) @(negedge clock);
        check_eq("tout_bad_pulses", n_bad - b0, 1);
        check_eq("tout_delay", t_bad - t_load, TimeoutCycles);
        check_eq("tout_state", 32'(dut.state_q), 32'(StHunt));
        check_eq("tout_bad_count", bad_count, 3);
        check_eq("tout_sb_drained", sbq.size(), 0);

        // Reset mid-Feed drops the sentence silently
        make_sentence("GPZDA,201536.00,04,07,2002,00,00");
        send_sent(6, 10);
        repeat (2) @(negedge clock);
        check_eq("pre_reset_in_feed", 32'(dut.state_q), 32'(StFeed));
        b0 = n_bad;
        reset_n = 1'b0;
        #1;
        check_outputs_zero("midreset");
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
        sbq.delete();
        l0 = n_load;
        send_junk("ABCD");
        repeat (10) @(negedge clock);
        check_eq("postreset_no_loads", n_load - l0, 0);
        check_eq("postreset_no_bad", n_bad - b0, 0);
        make_sentence("GPZDA,201537.00,04,07,2002,00,00");
        send_sent(sent.size(), 10);
        repeat (30) @(negedge clock);
        check_eq("postreset_counts", {good_count, bad_count}, {16'd1, 16'd0});
        check_eq("postreset_no_bad_total", n_bad - b0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
